inst_align: RTL and testbench
=============================

INST_ALIGN -- requirements
Module: inst_align

Interface
REQ-001 Parameter ROM_ORI, default 32'h0000_0000, reset value of the internal word-buffer tag.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 fet_pc_i  input  32  current fetch PC, halfword-aligned (bit 0 ignored).
REQ-005 fet_req_i  input  1  fetch stage requests the instruction at fet_pc_i.
REQ-006 flush_i  input  1  PC redirect; abandon the current access.
REQ-007 mem_req_o  output  1  word read request to instruction memory.
REQ-008 mem_addr_o  output  32  word address, bits [1:0] always 0.
REQ-009 mem_gnt_i  input  1  memory accepts the request this cycle.
REQ-010 mem_rvalid_i  input  1  read data valid; exactly one per granted request, earliest one cycle after grant.
REQ-011 mem_rdata_i  input  32  read data.
REQ-012 inst_o  output  32  aligned instruction; compressed instructions zero-extended in [31:16].
REQ-013 inst_valid_o  output  1  inst_o, com_inst_o and inst_pc_o are valid this cycle.
REQ-014 com_inst_o  output  1  inst_o is 16-bit (inst_o[1:0] != 2'b11).
REQ-015 inst_pc_o  output  32  PC of the instruction on inst_o.

Function
REQ-016 One-entry word buffer: tag buf_tag[29:0], data buf_data[31:0], flag buf_vld.
REQ-017 Lo word = {fet_pc_i[31:2],2'b00}; hi word = lo word + 4, 32-bit wrap-around (0xFFFF_FFFC -> 0x0000_0000).
REQ-018 Halfword hw0 = fet_pc_i[1] ? word[31:16] : word[15:0].
REQ-019 Instruction is 32-bit when hw0[1:0]==2'b11; spanning when fet_pc_i[1]==1 and 32-bit.
REQ-020 FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI.
REQ-021 IDLE: fet_req_i with buffer hit (buf_vld, buf_tag==fet_pc_i[31:2]), not spanning -> inst_valid_o=1 combinationally, same cycle, stay IDLE.
REQ-022 IDLE: fet_req_i with miss -> REQ_LO; hit but spanning -> REQ_HI, hi half of inst_o from upcoming hi word.
REQ-023 REQ_LO/REQ_HI: mem_req_o=1, mem_addr_o=lo/hi word; mem_gnt_i -> WAIT_LO/WAIT_HI; no grant -> hold request and address stable.
REQ-024 WAIT_LO on mem_rvalid_i: load buffer with lo word; non-spanning -> inst_valid_o=1 that cycle from mem_rdata_i, -> IDLE; spanning -> REQ_HI.
REQ-025 WAIT_HI on mem_rvalid_i: inst_o={mem_rdata_i[15:0], buf_data[31:16]}, inst_valid_o=1, buffer reloaded with hi word (tag = hi word), -> IDLE.
REQ-026 Latency: hit 0 cycles; miss non-spanning 2 cycles with immediate grant and 1-cycle rvalid; spanning miss 4 cycles; spanning hit 2 cycles.
REQ-027 inst_valid_o never asserted without fet_req_i; fet_pc_i held stable by fetch while waiting.
REQ-028 flush_i in REQ_*: drop request, -> IDLE next cycle, no inst_valid_o.
REQ-029 flush_i in WAIT_*: -> drain state; the outstanding rvalid is consumed, buffer written with its word, no inst_valid_o; then IDLE.
REQ-030 flush_i has priority over fet_req_i in the same cycle; inst_valid_o forced 0.
REQ-031 inst_pc_o = {fet_pc_i[31:1],1'b0} whenever inst_valid_o=1.

Reset
REQ-032 rst_i: state=IDLE, buf_vld=0, buf_tag=ROM_ORI[31:2], buf_data=0.
REQ-033 During and after reset until state change: mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, com_inst_o=0, inst_pc_o=0.
REQ-034 Reset mid-access aborts it; a later stray mem_rvalid_i in IDLE is ignored.

Structure
REQ-035 FSM state encodings and the RV compressed-opcode test (bits[1:0]!=2'b11) live in shared package rv_fetch_pkg.
REQ-036 One natural sub-module: inst_buf (tag/data/valid register with hit compare); all else inline.

Verification
REQ-037 Reset then fet_req_i, pc=0x0, rdata 0x0000_0013 after 1-cycle grant+rvalid -> inst_o=0x0000_0013, com_inst_o=0, valid at cycle 2.
REQ-038 Buffer word 0x0001_4501 at 0x0; pc=0x0 then 0x2 -> inst_o 0x4501 then 0x0001 with com_inst_o=1, each zero-latency, no mem_req_o.
REQ-039 pc=0x6, word@0x4=0x0093_xxxx, word@0x8=0x0000_0010 -> two reads (0x4, 0x8), inst_o=0x0010_0093, com_inst_o=0.
REQ-040 pc=0xFFFF_FFFE spanning -> hi read at mem_addr_o=0x0000_0000.
REQ-041 mem_gnt_i low 3 cycles -> mem_req_o and mem_addr_o held constant; flush_i in WAIT_LO -> rvalid absorbed, no inst_valid_o.
REQ-042 rst_i asserted in WAIT_HI -> next cycle all outputs 0, buf_vld=0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side definitions: alignment FSM encoding and the RV compressed-opcode test.
package rv_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = XLEN - 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_LO  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_REQ_HI  = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DRAIN   = 3'd5
  } fetch_state_e;

  // An RV instruction is 16-bit unless its two lowest opcode bits are both set.
  function automatic logic is_compressed(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/inst_buf.sv
// One-entry instruction word buffer: tag/data/valid register with a hit compare.
module inst_buf
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] ROM_ORI = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_data,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_hit,
  output logic [XLEN-1:0]  o_data
);

  logic             r_vld;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_data;

  // NOTE: sequential state is updated with <= only, so every reader sees the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld  <= 1'b0;
      r_tag  <= ROM_ORI[31:2];
      r_data <= '0;
    end else if (i_wr_en) begin
      r_vld  <= 1'b1;
      r_tag  <= i_wr_tag;
      r_data <= i_wr_data;
    end
  end

  assign o_hit  = r_vld && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule

// File: rtl/inst_align.sv
// Instruction aligner: turns halfword-aligned fetch PCs into whole instructions from word reads.
module inst_align
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] ROM_ORI = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fet_pc_i,
  input  logic        fet_req_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        com_inst_o,
  output logic [31:0] inst_pc_o
);

  fetch_state_e     r_state, w_next_state;
  logic [TAG_W-1:0] r_pend_tag, w_next_pend_tag;

  logic [31:0]      w_pc, w_lo_addr, w_hi_addr;
  logic             w_hit;
  logic [31:0]      w_buf_data;
  logic [15:0]      w_buf_hw0, w_mem_hw0;
  logic             w_buf_span, w_mem_span;
  logic             w_wr_en, w_valid;
  logic [31:0]      w_inst;

  assign w_pc      = fet_pc_i & 32'hFFFF_FFFE;
  assign w_lo_addr = {w_pc[31:2], 2'b00};
  assign w_hi_addr = w_lo_addr + 32'd4;

  assign w_buf_hw0  = w_pc[1] ? w_buf_data[31:16] : w_buf_data[15:0];
  assign w_mem_hw0  = w_pc[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  assign w_buf_span = w_pc[1] && !is_compressed(w_buf_hw0[1:0]);
  assign w_mem_span = w_pc[1] && !is_compressed(w_mem_hw0[1:0]);

  // Buffer writes always carry the tag of the word that was actually granted, even after a flush.
  inst_buf #(.ROM_ORI(ROM_ORI)) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_wr_en      (w_wr_en),
    .i_wr_tag     (r_pend_tag),
    .i_wr_data    (mem_rdata_i),
    .i_lookup_tag (w_pc[31:2]),
    .o_hit        (w_hit),
    .o_data       (w_buf_data)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_pend_tag = r_pend_tag;
    w_wr_en         = 1'b0;
    w_valid         = 1'b0;
    w_inst          = '0;
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (fet_req_i && !flush_i) begin
          if (!w_hit)          w_next_state = ST_REQ_LO;
          else if (w_buf_span) w_next_state = ST_REQ_HI;
          else begin
            w_valid = 1'b1;
            w_inst  = is_compressed(w_buf_hw0[1:0]) ? {16'h0, w_buf_hw0} : w_buf_data;
          end
        end
      end
      ST_REQ_LO, ST_REQ_HI: begin
        if (flush_i) w_next_state = ST_IDLE;
        else begin
          mem_req_o  = 1'b1;
          mem_addr_o = (r_state == ST_REQ_LO) ? w_lo_addr : w_hi_addr;
          if (mem_gnt_i) begin
            w_next_state    = (r_state == ST_REQ_LO) ? ST_WAIT_LO : ST_WAIT_HI;
            w_next_pend_tag = mem_addr_o[31:2];
          end
        end
      end
      ST_WAIT_LO: begin
        if (mem_rvalid_i) begin
          w_wr_en = 1'b1;
          if (flush_i)         w_next_state = ST_IDLE;
          else if (w_mem_span) w_next_state = ST_REQ_HI;
          else begin
            w_next_state = ST_IDLE;
            w_valid      = 1'b1;
            w_inst       = is_compressed(w_mem_hw0[1:0]) ? {16'h0, w_mem_hw0} : mem_rdata_i;
          end
        end else if (flush_i) w_next_state = ST_DRAIN;
      end
      ST_WAIT_HI: begin
        if (mem_rvalid_i) begin
          w_wr_en      = 1'b1;
          w_next_state = ST_IDLE;
          w_valid      = !flush_i;
          w_inst       = {mem_rdata_i[15:0], w_buf_data[31:16]};
        end else if (flush_i) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_rvalid_i) begin
          w_wr_en      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pend_tag <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pend_tag <= w_next_pend_tag;
    end
  end

  // Outputs are zero whenever nothing valid is presented.
  assign inst_valid_o = w_valid && fet_req_i && !flush_i;
  assign inst_o       = inst_valid_o ? w_inst : '0;
  assign com_inst_o   = inst_valid_o && is_compressed(w_inst[1:0]);
  assign inst_pc_o    = inst_valid_o ? w_pc : '0;

endmodule

// File: tb/tb_inst_align.sv
// Directed, table-driven bench for inst_align: one row per clock cycle of stimulus and expectations.
module tb_inst_align;

  logic        clk_i = 1'b0;
  logic        rst_i, fet_req_i, flush_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] fet_pc_i, mem_rdata_i;
  logic        mem_req_o, inst_valid_o, com_inst_o;
  logic [31:0] mem_addr_o, inst_o, inst_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  inst_align #(.ROM_ORI(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fet_pc_i     (fet_pc_i),
    .fet_req_i    (fet_req_i),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .com_inst_o   (com_inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  typedef struct {
    logic        rst, req, flush;
    logic [31:0] pc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_com;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic req, logic flush, logic [31:0] pc, logic gnt,
                              logic rv, logic [31:0] rdata, logic e_mreq, logic [31:0] e_maddr,
                              logic e_valid, logic [31:0] e_inst, logic e_com, logic [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.req = req; v.flush = flush; v.pc = pc; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_com = e_com; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, compare on the falling edge.
  task automatic run(input string tag, input vec_t v);
    @(posedge clk_i);
    #1;
    rst_i = v.rst; fet_req_i = v.req; flush_i = v.flush; fet_pc_i = v.pc;
    mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_rdata_i = v.rdata;
    @(negedge clk_i);
    check({tag, " mem_req"},    {31'h0, mem_req_o},    {31'h0, v.e_mreq});
    check({tag, " mem_addr"},   mem_addr_o,            v.e_maddr);
    check({tag, " inst_valid"}, {31'h0, inst_valid_o}, {31'h0, v.e_valid});
    check({tag, " inst"},       inst_o,                v.e_inst);
    check({tag, " com_inst"},   {31'h0, com_inst_o},   {31'h0, v.e_com});
    check({tag, " inst_pc"},    inst_pc_o,             v.e_ipc);
  endtask

  vec_t vecs[30];

  initial begin
    rst_i = 1'b1; fet_req_i = 1'b0; flush_i = 1'b0; fet_pc_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);

    //           rst req fl pc            gnt rv rdata          mreq maddr        vld inst          com ipc
    vecs[0]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    // miss at 0x0, 2-cycle latency
    vecs[1]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 32'h0,          0, 1, 32'h0000_0013,  0, 32'h0,          1, 32'h0000_0013,  0, 32'h0);
    vecs[4]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0013,  0, 32'h0);
    // two compressed halves of one buffered word
    vecs[5]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h0,          0, 1, 32'h0001_4501,  0, 32'h0,          1, 32'h0000_4501,  1, 32'h0);
    vecs[9]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_4501,  1, 32'h0);
    vecs[10] = mk(0, 1, 0, 32'h2,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0001,  1, 32'h2);
    // spanning miss at 0x6
    vecs[11] = mk(0, 1, 0, 32'h6,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[12] = mk(0, 1, 0, 32'h6,          1, 0, 32'h0,          1, 32'h4,          0, 32'h0,          0, 32'h0);
    vecs[13] = mk(0, 1, 0, 32'h6,          0, 1, 32'h0093_1234,  0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[14] = mk(0, 1, 0, 32'h6,          1, 0, 32'h0,          1, 32'h8,          0, 32'h0,          0, 32'h0);
    vecs[15] = mk(0, 1, 0, 32'h6,          0, 1, 32'h0000_0010,  0, 32'h0,          1, 32'h0010_0093,  0, 32'h6);
    // spanning at the top of the address space wraps the hi read to 0x0
    vecs[16] = mk(0, 1, 0, 32'hFFFF_FFFE,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[17] = mk(0, 1, 0, 32'hFFFF_FFFE,  1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          0, 32'h0);
    vecs[18] = mk(0, 1, 0, 32'hFFFF_FFFE,  0, 1, 32'h0517_0000,  0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[19] = mk(0, 1, 0, 32'hFFFF_FFFE,  1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[20] = mk(0, 1, 0, 32'hFFFF_FFFE,  0, 1, 32'h0000_ABCD,  0, 32'h0,          1, 32'hABCD_0517,  0, 32'hFFFF_FFFE);
    // compressed at 0x10, then spanning hit at 0x12 (2 cycles), then hi-word reuse at 0x14
    vecs[21] = mk(0, 1, 0, 32'h10,         0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[22] = mk(0, 1, 0, 32'h10,         1, 0, 32'h0,          1, 32'h10,         0, 32'h0,          0, 32'h0);
    vecs[23] = mk(0, 1, 0, 32'h10,         0, 1, 32'h0093_4501,  0, 32'h0,          1, 32'h0000_4501,  1, 32'h10);
    vecs[24] = mk(0, 1, 0, 32'h12,         0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[25] = mk(0, 1, 0, 32'h12,         1, 0, 32'h0,          1, 32'h14,         0, 32'h0,          0, 32'h0);
    vecs[26] = mk(0, 1, 0, 32'h12,         0, 1, 32'h0000_0010,  0, 32'h0,          1, 32'h0010_0093,  0, 32'h12);
    vecs[27] = mk(0, 0, 0, 32'h14,         0, 1, 32'hDEAD_BEEF,  0, 32'h0,          0, 32'h0,          0, 32'h0);
    vecs[28] = mk(0, 1, 0, 32'h14,         0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0010,  1, 32'h14);
    vecs[29] = mk(0, 1, 1, 32'h14,         0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);

    for (int i = 0; i < 30; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Grant held off three cycles, then flush while waiting: the word is drained into the buffer.
    run("stall_req",   mk(0, 1, 0, 32'h40, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));
    for (int i = 0; i < 3; i++)
      run($sformatf("stall%0d", i), mk(0, 1, 0, 32'h40, 0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 32'h0));
    run("stall_gnt",   mk(0, 1, 0, 32'h40, 1, 0, 32'h0,  1, 32'h40, 0, 32'h0,  0, 32'h0));
    run("wait_flush",  mk(0, 1, 1, 32'h40, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));
    run("drain_rv",    mk(0, 1, 0, 32'h40, 0, 1, 32'h13, 0, 32'h0,  0, 32'h0,  0, 32'h0));
    run("drained_hit", mk(0, 1, 0, 32'h40, 0, 0, 32'h0,  0, 32'h0,  1, 32'h13, 0, 32'h40));
    // Flush while requesting drops the request and returns to idle.
    run("req_lo",      mk(0, 1, 0, 32'h80, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));
    run("req_flush",   mk(0, 1, 1, 32'h80, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));
    run("after_flush", mk(0, 1, 0, 32'h80, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));
    run("flush_again", mk(0, 1, 1, 32'h80, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0));

    // Reset in WAIT_HI: outputs clear, a stray rvalid is ignored and the buffer is invalid.
    run("span_req",    mk(0, 1, 0, 32'h22, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 0, 32'h0));
    run("span_gnt_lo", mk(0, 1, 0, 32'h22, 1, 0, 32'h0,         1, 32'h20, 0, 32'h0, 0, 32'h0));
    run("span_rv_lo",  mk(0, 1, 0, 32'h22, 0, 1, 32'h0093_0000, 0, 32'h0,  0, 32'h0, 0, 32'h0));
    run("span_gnt_hi", mk(0, 1, 0, 32'h22, 1, 0, 32'h0,         1, 32'h24, 0, 32'h0, 0, 32'h0));
    run("rst_wait_hi", mk(1, 1, 0, 32'h22, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 0, 32'h0));
    run("stray_rv",    mk(0, 0, 0, 32'h22, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,  0, 32'h0, 0, 32'h0));
    run("buf_cleared", mk(0, 1, 0, 32'h20, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 0, 32'h0));
    run("refetch",     mk(0, 1, 0, 32'h20, 0, 0, 32'h0,         1, 32'h20, 0, 32'h0, 0, 32'h0));
    run("final_flush", mk(0, 1, 1, 32'h20, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
